// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage.
//   - funct3 encodings for loads and stores
//   - major opcode constants for LOAD / STORE
//   - memory-stage FSM state type
//   - alignment helper used by the MEM stage
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Size comes from funct3[1:0]; byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] ea_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = ea_lo[0];
      2'b10:   mis = (ea_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection and extension.
//   rdata  : full 32-bit word returned by data memory
//   offset : byte offset of the effective address
//   funct3 : load type (LB/LH/LW/LBU/LHU, 11x treated as word)
//   data   : selected lane, sign- or zero-extended to 32 bits
module mem_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic        [31:0] shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  data = {24'd0, lane_b};
      F3_LHU:  data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM pipeline stage: EX/MEM register, data-memory handshake FSM,
// store lane steering and load extension toward WB.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_valid .. i_pass      : EX-stage instruction, controls and sideband
//   o_stall                : freeze upstream while a request waits for ack
//   o_dmem_*/i_dmem_*      : word-aligned data memory port
//   o_valid .. o_pass      : combinational results to WB
module mem_stage
  import rv32i_pkg::*;
#(
  parameter int PASS_W = 192
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_rs2_data,
  input  logic [2:0]        i_funct3,
  input  logic [4:0]        i_rd,
  input  logic [PASS_W-1:0] i_pass,
  output logic              o_stall,
  output logic              o_dmem_req,
  output logic [31:0]       o_dmem_addr,
  output logic              o_dmem_wen,
  output logic [3:0]        o_dmem_mask,
  output logic [31:0]       o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [31:0]       i_dmem_rdata,
  output logic              o_valid,
  output logic [31:0]       o_mem_read_data,
  output logic [31:0]       o_mem_read_data_raw,
  output logic [31:0]       o_alu_result,
  output logic [4:0]        o_rd,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [2:0]        o_funct3,
  output logic [31:0]       o_dmem_addr_full,
  output logic [1:0]        o_byte_offset,
  output logic [3:0]        o_mask,
  output logic [31:0]       o_wdata,
  output logic              o_unaligned_mem,
  output logic [PASS_W-1:0] o_pass
);

  function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                            input logic [1:0] off);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicating the narrow datum to every lane lets the mask alone pick the target bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                              input logic [31:0] rs2);
    logic [31:0] w;
    case (funct3[1:0])
      2'b00:   w = {4{rs2[7:0]}};
      2'b01:   w = {2{rs2[15:0]}};
      default: w = rs2;
    endcase
    return w;
  endfunction

  // ---- EX -> MEM boundary (p1) ----
  logic              vld_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic              reg_write_p1;
  logic              mem_to_reg_p1;
  logic [31:0]       alu_p1;
  logic [31:0]       rs2_p1;
  logic [2:0]        funct3_p1;
  logic [4:0]        rd_p1;
  logic [PASS_W-1:0] pass_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1        <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_p1        <= '0;
      rs2_p1        <= '0;
      funct3_p1     <= '0;
      rd_p1         <= '0;
      pass_p1       <= '0;
    end else if (!o_stall) begin
      vld_p1        <= i_valid;
      mem_read_p1   <= i_mem_read;
      mem_write_p1  <= i_mem_write;
      reg_write_p1  <= i_reg_write;
      mem_to_reg_p1 <= i_mem_to_reg;
      alu_p1        <= i_alu_result;
      rs2_p1        <= i_rs2_data;
      funct3_p1     <= i_funct3;
      rd_p1         <= i_rd;
      pass_p1       <= i_pass;
    end
  end

  logic misaligned;
  logic mem_access;
  logic mem_op;

  assign misaligned = is_misaligned(funct3_p1, alu_p1[1:0]);
  assign mem_access = vld_p1 & (mem_read_p1 | mem_write_p1);
  assign mem_op     = mem_access & ~misaligned;

  mem_state_e state_q;
  mem_state_e state_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op && !i_dmem_ack) state_d = ST_WAIT;
      ST_WAIT: if (i_dmem_ack)            state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // The request is held in both states; the FSM only remembers that we are waiting.
  always_comb begin
    o_dmem_req = 1'b0;
    case (state_q)
      ST_IDLE: o_dmem_req = mem_op;
      ST_WAIT: o_dmem_req = mem_op;
      default: o_dmem_req = 1'b0;
    endcase
  end

  // Stall is combinational so the first cycle of a slow access is already frozen.
  assign o_stall = o_dmem_req & ~i_dmem_ack;

  logic [31:0] load_ext;
  logic        load_done;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;

  mem_load_align u_load_align (
    .rdata  (i_dmem_rdata),
    .offset (alu_p1[1:0]),
    .funct3 (funct3_p1),
    .data   (load_ext)
  );

  assign load_done  = o_dmem_req & i_dmem_ack & mem_read_p1;
  assign lane_mask  = (mem_op & mem_write_p1) ? store_mask(funct3_p1, alu_p1[1:0]) : 4'b0000;
  assign lane_wdata = store_wdata(funct3_p1, rs2_p1);

  assign o_dmem_addr  = {alu_p1[31:2], 2'b00};
  assign o_dmem_wen   = mem_write_p1;
  assign o_dmem_mask  = lane_mask;
  assign o_dmem_wdata = lane_wdata;

  // ---- MEM -> WB boundary (combinational) ----
  assign o_valid             = vld_p1 & ~o_stall;
  assign o_mem_read_data     = load_done ? load_ext : 32'd0;
  assign o_mem_read_data_raw = i_dmem_rdata;
  assign o_alu_result        = alu_p1;
  assign o_rd                = rd_p1;
  assign o_reg_write         = reg_write_p1;
  assign o_mem_to_reg        = mem_to_reg_p1;
  assign o_mem_read          = mem_read_p1;
  assign o_mem_write         = mem_write_p1;
  assign o_funct3            = funct3_p1;
  assign o_dmem_addr_full    = alu_p1;
  assign o_byte_offset       = alu_p1[1:0];
  assign o_mask              = lane_mask;
  assign o_wdata             = lane_wdata;
  assign o_unaligned_mem     = mem_access & misaligned;
  assign o_pass              = pass_p1;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int PASS_W = 192;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg;
  logic [31:0]       i_alu_result, i_rs2_data;
  logic [2:0]        i_funct3;
  logic [4:0]        i_rd;
  logic [PASS_W-1:0] i_pass;
  logic              o_stall, o_dmem_req, o_dmem_wen;
  logic [31:0]       o_dmem_addr, o_dmem_wdata;
  logic [3:0]        o_dmem_mask;
  logic              i_dmem_ack;
  logic [31:0]       i_dmem_rdata;
  logic              o_valid;
  logic [31:0]       o_mem_read_data, o_mem_read_data_raw, o_alu_result;
  logic [4:0]        o_rd;
  logic              o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write;
  logic [2:0]        o_funct3;
  logic [31:0]       o_dmem_addr_full;
  logic [1:0]        o_byte_offset;
  logic [3:0]        o_mask;
  logic [31:0]       o_wdata;
  logic              o_unaligned_mem;
  logic [PASS_W-1:0] o_pass;

  always #5 i_clk = ~i_clk;

  mem_stage #(.PASS_W(PASS_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(i_valid), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data),
    .i_funct3(i_funct3), .i_rd(i_rd), .i_pass(i_pass),
    .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wen(o_dmem_wen), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_valid(o_valid), .o_mem_read_data(o_mem_read_data),
    .o_mem_read_data_raw(o_mem_read_data_raw), .o_alu_result(o_alu_result),
    .o_rd(o_rd), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_funct3(o_funct3),
    .o_dmem_addr_full(o_dmem_addr_full), .o_byte_offset(o_byte_offset),
    .o_mask(o_mask), .o_wdata(o_wdata), .o_unaligned_mem(o_unaligned_mem),
    .o_pass(o_pass)
  );

  typedef struct {
    logic              is_store;
    logic [31:0]       rdata;
    logic [3:0]        mask;
    logic [31:0]       wdata;
    logic              unal;
    logic [4:0]        rd;
    logic [PASS_W-1:0] pass;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pass(input string tag, input logic [PASS_W-1:0] obs,
                          input logic [PASS_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load: pick bytes from a byte array, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] word,
                                             input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [7:0]  by [4];
    logic [7:0]  b;
    logic [15:0] h;
    for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
    b = by[off];
    h = {by[{off[1], 1'b1}], by[{off[1], 1'b0}]};
    case (f3)
      3'b000:  return b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
      3'b001:  return h[15] ? {16'hFFFF, h}   : {16'h0, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                      (off == 2'd2) ? 4'b0100 : 4'b1000;
      3'b001:  return (off == 2'd0) ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bubble();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_reg_write = 1'b0; i_mem_to_reg = 1'b0;
  endtask

  // Drive an EX instruction and push its expected WB result.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] ea,
                       input logic [31:0] rs2, input logic [4:0] rd,
                       input logic [PASS_W-1:0] pass, input logic [31:0] word,
                       input logic unal);
    exp_t e;
    i_valid = 1'b1; i_mem_read = ~wr; i_mem_write = wr;
    i_reg_write = ~wr; i_mem_to_reg = ~wr;
    i_funct3 = f3; i_alu_result = ea; i_rs2_data = rs2; i_rd = rd; i_pass = pass;
    e.is_store = wr;
    e.unal     = unal;
    e.rd       = rd;
    e.pass     = pass;
    e.rdata    = (wr || unal) ? 32'd0 : model_load(word, ea[1:0], f3);
    e.mask     = unal ? 4'b0000 : model_mask(f3, ea[1:0]);
    case (f3[1:0])
      2'b00:   e.wdata = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
      2'b01:   e.wdata = {rs2[15:0], rs2[15:0]};
      default: e.wdata = rs2;
    endcase
    sb.push_back(e);
  endtask

  task automatic retire(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb: got retire expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, o_mem_read_data, e.rdata);
      chk({tag, "_unal"}, {31'd0, o_unaligned_mem}, {31'd0, e.unal});
      chk({tag, "_rd"}, {27'd0, o_rd}, {27'd0, e.rd});
      chk_pass({tag, "_pass"}, o_pass, e.pass);
      if (e.is_store) begin
        chk({tag, "_mask"}, {28'd0, o_mask}, {28'd0, e.mask});
        chk({tag, "_wdata"}, o_wdata, e.wdata);
      end
    end
  endtask

  localparam logic [PASS_W-1:0] P_A = {64'hA5A5_0000_1111_2222, 64'h3333_4444_5555_6666, 64'h7777_8888_9999_AAAA};
  localparam logic [PASS_W-1:0] P_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hC0DE_CAFE_BEEF_F00D};

  initial begin
    int vld_cnt;
    int stall_seen;
    bubble();
    i_alu_result = '0; i_rs2_data = '0; i_funct3 = '0; i_rd = '0; i_pass = '0;
    i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    i_rst = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_req",   {31'd0, o_dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_unal",  {31'd0, o_unaligned_mem}, 32'd0);
    chk("rst_mask",  {28'd0, o_mask}, 32'd0);
    i_rst = 1'b0;

    // SW 0xDEADBEEF @0x100, ack same cycle
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, P_A, 32'd0, 1'b0);
    tick(); bubble();
    i_dmem_ack = 1'b1; #1;
    chk("sw_req",   {31'd0, o_dmem_req}, 32'd1);
    chk("sw_wen",   {31'd0, o_dmem_wen}, 32'd1);
    chk("sw_addr",  o_dmem_addr, 32'h100);
    chk("sw_dmask", {28'd0, o_dmem_mask}, 32'hF);
    chk("sw_dwdata", o_dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall", {31'd0, o_stall}, 32'd0);
    chk("sw_valid", {31'd0, o_valid}, 32'd1);
    if (o_valid) retire("sw");
    tick(); i_dmem_ack = 1'b0;

    // LB @0x103, ack after three waiting cycles
    issue(1'b0, 3'b000, 32'h103, 32'd0, 5'd5, P_B, 32'h80AABBCC, 1'b0);
    tick(); bubble();
    i_dmem_rdata = 32'h80AABBCC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall", {31'd0, o_stall}, 32'd1);
      chk("lb_bubble", {31'd0, o_valid}, 32'd0);
      tick();
    end
    i_dmem_ack = 1'b1; #1;
    chk("lb_stall_end", {31'd0, o_stall}, 32'd0);
    chk("lb_valid", {31'd0, o_valid}, 32'd1);
    chk("lb_raw", o_mem_read_data_raw, 32'h80AABBCC);
    chk("lb_addr", o_dmem_addr, 32'h100);
    if (o_valid) retire("lb");
    tick(); i_dmem_ack = 1'b0;

    // LBU @0x103, ack after one waiting cycle
    issue(1'b0, 3'b100, 32'h103, 32'd0, 5'd6, P_B, 32'h80AABBCC, 1'b0);
    tick(); bubble(); #1;
    chk("lbu_stall", {31'd0, o_stall}, 32'd1);
    tick();
    i_dmem_ack = 1'b1; #1;
    chk("lbu_valid", {31'd0, o_valid}, 32'd1);
    if (o_valid) retire("lbu");
    tick(); i_dmem_ack = 1'b0;

    // SH 0x1234 @0x102
    issue(1'b1, 3'b001, 32'h102, 32'h0000_1234, 5'd0, P_A, 32'd0, 1'b0);
    tick(); bubble();
    i_dmem_ack = 1'b1; #1;
    chk("sh_dmask", {28'd0, o_dmem_mask}, 32'hC);
    chk("sh_dwdata", o_dmem_wdata, 32'h12341234);
    chk("sh_valid", {31'd0, o_valid}, 32'd1);
    if (o_valid) retire("sh");
    tick(); i_dmem_ack = 1'b0;

    // LH @0x101: misaligned, plus a stray ack that must be ignored
    issue(1'b0, 3'b001, 32'h101, 32'd0, 5'd7, P_A, 32'd0, 1'b1);
    tick(); bubble();
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h7FFF_7FFF; #1;
    chk("lhm_req", {31'd0, o_dmem_req}, 32'd0);
    chk("lhm_stall", {31'd0, o_stall}, 32'd0);
    chk("lhm_valid", {31'd0, o_valid}, 32'd1);
    if (o_valid) retire("lhm");
    tick(); i_dmem_ack = 1'b0;

    // LH @0x102 signed upper half
    issue(1'b0, 3'b001, 32'h102, 32'd0, 5'd8, P_B, 32'h9ABC_1234, 1'b0);
    tick(); bubble();
    i_dmem_rdata = 32'h9ABC_1234; i_dmem_ack = 1'b1; #1;
    chk("lh_valid", {31'd0, o_valid}, 32'd1);
    if (o_valid) retire("lh");
    tick(); i_dmem_ack = 1'b0;

    // Reset while waiting
    issue(1'b0, 3'b010, 32'h200, 32'd0, 5'd9, P_A, 32'd0, 1'b0);
    tick(); bubble(); #1;
    chk("rw_stall", {31'd0, o_stall}, 32'd1);
    tick();
    chk("rw_req_wait", {31'd0, o_dmem_req}, 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; #1;
    chk("rw_req", {31'd0, o_dmem_req}, 32'd0);
    chk("rw_valid", {31'd0, o_valid}, 32'd0);
    chk("rw_stall_clr", {31'd0, o_stall}, 32'd0);
    void'(sb.pop_front());  // the reset discards this load
    tick();
    i_dmem_ack = 1'b1; #1;
    chk("rw_late_ack_valid", {31'd0, o_valid}, 32'd0);
    chk("rw_late_ack_data", o_mem_read_data, 32'd0);
    tick(); i_dmem_ack = 1'b0;

    // Four back-to-back LWs with ack every cycle
    vld_cnt = 0;
    stall_seen = 0;
    i_dmem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) issue(1'b0, 3'b010, 32'h300 + 32'(4 * k), 32'd0, 5'(10 + k), P_B,
                       32'h1000_0000 + 32'(k - 1 + 1), 1'b0);
      else bubble();
      tick();
      i_dmem_rdata = 32'h1000_0000 + 32'(k);
      #1;
      if (o_stall) stall_seen++;
      if (o_valid) begin
        vld_cnt++;
        retire("lw4");
      end
    end
    i_dmem_ack = 1'b0;
    chk("lw4_count", 32'(vld_cnt), 32'd4);
    chk("lw4_stall", 32'(stall_seen), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter PASS_W, default 192: width of opaque sideband (pc, inst, rs1/rs2 addr+data, imm, opcode, next_pc, flags) forwarded untouched to WB.
REQ-002 i_clk  in  1  single clock; all state on posedge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_valid, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg  in  1 each  EX-stage instruction valid and controls.
REQ-005 i_alu_result  in  32  effective address / ALU value; i_rs2_data  in  32  store data; i_funct3  in  3; i_rd  in  5.
REQ-006 i_pass  in  PASS_W  sideband from EX.
REQ-007 o_stall  out  1  freeze PC/IF/ID/EX and hold EX outputs stable.
REQ-008 o_dmem_req  out  1; o_dmem_addr  out  32 (word aligned, [1:0]=0); o_dmem_wen  out  1; o_dmem_mask  out  4; o_dmem_wdata  out  32 (lane-shifted).
REQ-009 i_dmem_ack  in  1  request complete this cycle; i_dmem_rdata  in  32  word valid when ack and !wen.
REQ-010 To WB, combinational, in WB order: o_valid, o_mem_read_data (extended), o_mem_read_data_raw, o_alu_result, o_rd, o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write, o_funct3, o_dmem_addr_full (32, unaligned EA), o_byte_offset (2), o_mask (4), o_wdata (32), o_unaligned_mem (1), o_pass (PASS_W).

Function
REQ-011 EX/MEM register captures all i_* on each posedge when !o_stall; holds when o_stall=1.
REQ-012 FSM states IDLE, WAIT; reset -> IDLE.
REQ-013 mem_op = reg_valid & (reg_mem_read|reg_mem_write) & !misaligned.
REQ-014 misaligned: funct3[1:0]=01 with EA[0]=1, or funct3[1:0]=10 with EA[1:0]!=00; bytes never misaligned.
REQ-015 o_dmem_req = mem_op in IDLE or WAIT; o_dmem_wen = reg_mem_write.
REQ-016 IDLE: mem_op & ack -> stay IDLE (zero-wait); mem_op & !ack -> WAIT. WAIT: ack -> IDLE, else remain.
REQ-017 o_stall = o_dmem_req & !i_dmem_ack (combinational; covers first cycle).
REQ-018 o_valid = reg_valid & !o_stall; a stalled cycle sends a bubble to WB.
REQ-019 Misaligned access: no dmem request, o_valid=reg_valid, o_unaligned_mem=1, zero stall.
REQ-020 Store mask: SB 0001<<off, SH 0011<<off, SW 1111; wdata = rs2 byte/half replicated to all lanes.
REQ-021 Load: select lane by off; LB/LH sign-extend, LBU/LHU zero-extend, LW and funct3 11x return full word.
REQ-022 o_mem_read_data = 0 when not a completing load; o_mem_read_data_raw = i_dmem_rdata.
REQ-023 Ack with no request is ignored; ack on a store leaves rdata unused.
REQ-024 Back-to-back mem ops with single-cycle ack: one retire per cycle, no stall.

Reset
REQ-025 On i_rst: FSM=IDLE, all EX/MEM fields 0, so o_valid=0, o_dmem_req=0, o_stall=0, o_unaligned_mem=0, o_mask=0.
REQ-026 Reset in WAIT drops the request the same cycle; a late ack after reset is ignored.

Structure
REQ-027 Shared package rv32i_pkg: funct3 load/store encodings, opcode constants, FSM state typedef.
REQ-028 One combinational sub-module mem_load_align: (rdata, offset, funct3) -> extended data.

Verification
REQ-029 SW x=0xDEADBEEF @0x100, ack same cycle -> mask 1111, wdata 0xDEADBEEF, o_stall=0, o_valid=1.
REQ-030 LB @0x103, word 0x80AABBCC, ack after 3 cycles -> o_stall 1 for 3 cycles, then data 0xFFFFFF80; LBU -> 0x00000080.
REQ-031 SH 0x1234 @0x102 -> mask 1100, wdata 0x12341234; LH @0x101 -> no req, o_unaligned_mem=1, no stall.
REQ-032 i_rst asserted during WAIT -> next cycle o_dmem_req=0, o_valid=0, FSM IDLE; later ack produces no retire.
REQ-033 Four consecutive LWs with ack every cycle -> four o_valid cycles, o_stall never high, o_pass unchanged.
